// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared types and defaults for the store-buffer drain arbiter:
//               2-bit FSM state encoding, miss requester tag, and default
//               miss latency / starvation limit.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_MISS  = 2'd2,
        ST_FILL  = 2'd3
    } state_t;

    typedef enum logic {
        REQ_LOAD  = 1'b0,
        REQ_STORE = 1'b1
    } req_t;

    localparam int c_miss_lat_dflt   = 4;
    localparam int c_starve_max_dflt = 3;

endpackage : proc_pkg
`default_nettype wire

// File: rtl/sb_drain_arb.sv
`default_nettype none
// ============================================================================
// Module      : sb_drain_arb
// Description : Arbitrates the single D-cache port between pipeline loads and
//               store-buffer drains, with forced drain on a full buffer or
//               after repeated load wins, and a fixed-latency miss/fill path.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_drain_arb
    import proc_pkg::*;
#(
    parameter int MISS_LAT   = c_miss_lat_dflt,
    parameter int STARVE_MAX = c_starve_max_dflt
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic        sb_valid,
    input  logic        sb_full,
    input  logic [31:0] sb_addr,
    input  logic [31:0] sb_data,
    input  logic        dhit,
    output logic [31:0] dc_addr,
    output logic        dc_we,
    output logic [31:0] dc_wdata,
    output logic        sb_pop,
    output logic        ld_grant,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        stall
);

    // A latency of 1 still needs a 1-bit counter.
    localparam int             c_cw         = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;
    localparam logic [c_cw-1:0] c_lat_init  = c_cw'(MISS_LAT - 1);
    localparam logic [1:0]      c_starve_max = 2'(STARVE_MAX);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_cw-1:0] r_cnt;
    logic [c_cw-1:0] w_cnt_nxt;
    logic [1:0]      r_starve;
    logic [1:0]      w_starve_nxt;
    logic [31:2]     r_miss_addr;
    logic [31:2]     w_miss_addr_nxt;
    req_t            r_req;
    req_t            w_req_nxt;
    logic            r_ret;
    logic            w_ret_nxt;
    logic            w_force;
    logic            w_drain_win;

    // State, counters and miss bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_starve    <= 2'd0;
            r_miss_addr <= '0;
            r_req       <= REQ_LOAD;
            r_ret       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_starve    <= w_starve_nxt;
            r_miss_addr <= w_miss_addr_nxt;
            r_req       <= w_req_nxt;
            r_ret       <= w_ret_nxt;
        end
    end

    // Next-state, arbitration and output decode; all outputs held low in reset.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_miss_addr_nxt = r_miss_addr;
        w_req_nxt       = r_req;
        w_ret_nxt       = 1'b0;
        w_force         = 1'b0;
        w_drain_win     = 1'b0;
        dc_addr         = 32'd0;
        dc_we           = 1'b0;
        dc_wdata        = 32'd0;
        sb_pop          = 1'b0;
        ld_grant        = 1'b0;
        mem_req         = 1'b0;
        mem_addr        = 32'd0;
        stall           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // A store that just completed its own fill re-arbitrates
                // ahead of loads so it lands on the line it fetched.
                w_force     = sb_valid && (sb_full || (r_starve == c_starve_max) ||
                                           (r_ret && (r_req == REQ_STORE)));
                w_drain_win = w_force || (sb_valid && !ld_req);
                if (w_drain_win) begin
                    dc_addr = sb_addr;
                    if (dhit) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_miss_addr_nxt = sb_addr[31:2];
                        w_req_nxt       = REQ_STORE;
                        w_state_nxt     = ST_MISS;
                    end
                end else if (ld_req) begin
                    dc_addr = ld_addr;
                    if (dhit) begin
                        ld_grant = 1'b1;
                    end else begin
                        w_miss_addr_nxt = ld_addr[31:2];
                        w_req_nxt       = REQ_LOAD;
                        w_state_nxt     = ST_MISS;
                    end
                end
            end
            ST_DRAIN: begin
                dc_we       = 1'b1;
                dc_wdata    = sb_data;
                sb_pop      = sb_valid;
                w_state_nxt = ST_IDLE;
            end
            ST_MISS: begin
                mem_req     = 1'b1;
                mem_addr    = {r_miss_addr, 2'b00};
                w_cnt_nxt   = c_lat_init;
                w_state_nxt = ST_FILL;
            end
            default: begin
                // FILL: the cycle that decrements the counter to zero is the
                // last one with mem_req, giving MISS_LAT request cycles total.
                mem_req  = 1'b1;
                mem_addr = {r_miss_addr, 2'b00};
                if (r_cnt <= c_cw'(1)) begin
                    w_cnt_nxt   = '0;
                    w_ret_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_cw'(1);
                end
            end
        endcase

        stall = (ld_req && !ld_grant) || (r_state == ST_MISS) || (r_state == ST_FILL);

        if (reset) begin
            dc_addr  = 32'd0;
            dc_we    = 1'b0;
            dc_wdata = 32'd0;
            sb_pop   = 1'b0;
            ld_grant = 1'b0;
            mem_req  = 1'b0;
            mem_addr = 32'd0;
            stall    = 1'b0;
        end
    end

    // Starvation counter: counts loads granted over a waiting store, saturating.
    always_comb begin
        w_starve_nxt = r_starve;
        if (sb_pop || !sb_valid) begin
            w_starve_nxt = 2'd0;
        end else if ((r_state == ST_IDLE) && ld_grant && (r_starve != c_starve_max)) begin
            w_starve_nxt = r_starve + 2'd1;
        end
    end

endmodule : sb_drain_arb
`default_nettype wire

// File: tb/tb_sb_drain_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_sb_drain_arb
// Description : Directed self-checking bench for sb_drain_arb: reset, load
//               hit, opportunistic drain, load miss, full-buffer priority,
//               starvation-forced drain and reset during fill.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sb_drain_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        sb_valid;
    logic        sb_full;
    logic [31:0] sb_addr;
    logic [31:0] sb_data;
    logic        dhit;
    logic [31:0] dc_addr;
    logic        dc_we;
    logic [31:0] dc_wdata;
    logic        sb_pop;
    logic        ld_grant;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        stall;

    int checks = 0;
    int errors = 0;

    sb_drain_arb #(
        .MISS_LAT   (4),
        .STARVE_MAX (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ld_req   (ld_req),
        .ld_addr  (ld_addr),
        .sb_valid (sb_valid),
        .sb_full  (sb_full),
        .sb_addr  (sb_addr),
        .sb_data  (sb_data),
        .dhit     (dhit),
        .dc_addr  (dc_addr),
        .dc_we    (dc_we),
        .dc_wdata (dc_wdata),
        .sb_pop   (sb_pop),
        .ld_grant (ld_grant),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic lr, input logic [31:0] la, input logic sv,
                         input logic sf, input logic [31:0] sa, input logic [31:0] sd,
                         input logic dh);
        ld_req   = lr;
        ld_addr  = la;
        sb_valid = sv;
        sb_full  = sf;
        sb_addr  = sa;
        sb_data  = sd;
        dhit     = dh;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 32'h1, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (dc_addr !== 32'd0)  begin errors++; $display("FAIL rst_dc_addr: got %h want 0", dc_addr); end
        checks++; if (ld_grant !== 1'b0)  begin errors++; $display("FAIL rst_ld_grant: got %b want 0", ld_grant); end
        checks++; if (stall !== 1'b0)     begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
        checks++; if (mem_req !== 1'b0)   begin errors++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        checks++; if (sb_pop !== 1'b0 || dc_we !== 1'b0) begin errors++; $display("FAIL rst_pop_we: got %b%b want 00", sb_pop, dc_we); end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        checks++; if (stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rst_release: stall %b mem_req %b want 0 0", stall, mem_req); end
    endtask

    task automatic test_load_hit;
        @(negedge clk);
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        #1;
        checks++; if (ld_grant !== 1'b1)     begin errors++; $display("FAIL hit_grant: got %b want 1", ld_grant); end
        checks++; if (stall !== 1'b0)        begin errors++; $display("FAIL hit_stall: got %b want 0", stall); end
        checks++; if (dc_we !== 1'b0)        begin errors++; $display("FAIL hit_we: got %b want 0", dc_we); end
        checks++; if (dc_addr !== 32'h100)   begin errors++; $display("FAIL hit_addr: got %h want 100", dc_addr); end
    endtask

    task automatic test_drain;
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'hDEADBEEF, 1'b1);
        #1;
        checks++; if (dc_addr !== 32'h200)   begin errors++; $display("FAIL drn_arb_addr: got %h want 200", dc_addr); end
        checks++; if (dc_we !== 1'b0 || sb_pop !== 1'b0) begin errors++; $display("FAIL drn_arb_we_pop: got %b%b want 00", dc_we, sb_pop); end
        @(negedge clk);
        #1;
        checks++; if (dc_we !== 1'b1)             begin errors++; $display("FAIL drn_we: got %b want 1", dc_we); end
        checks++; if (dc_wdata !== 32'hDEADBEEF)  begin errors++; $display("FAIL drn_wdata: got %h want deadbeef", dc_wdata); end
        checks++; if (sb_pop !== 1'b1)            begin errors++; $display("FAIL drn_pop: got %b want 1", sb_pop); end
        checks++; if (dc_addr !== 32'd0)          begin errors++; $display("FAIL drn_addr_zero: got %h want 0", dc_addr); end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        #1;
        checks++; if (sb_pop !== 1'b0 || dc_we !== 1'b0) begin errors++; $display("FAIL drn_one_cycle: pop %b we %b want 0 0", sb_pop, dc_we); end
    endtask

    task automatic test_miss;
        @(negedge clk);
        drive(1'b1, 32'h304, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        checks++; if (stall !== 1'b1 || ld_grant !== 1'b0) begin errors++; $display("FAIL miss_arb: stall %b grant %b want 1 0", stall, ld_grant); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL miss_arb_req: got %b want 0", mem_req); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++; if (mem_req !== 1'b1)      begin errors++; $display("FAIL miss_req[%0d]: got %b want 1", i, mem_req); end
            checks++; if (mem_addr !== 32'h304)  begin errors++; $display("FAIL miss_addr[%0d]: got %h want 304", i, mem_addr); end
            checks++; if (stall !== 1'b1)        begin errors++; $display("FAIL miss_stall[%0d]: got %b want 1", i, stall); end
        end
        @(negedge clk);
        dhit = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0)   begin errors++; $display("FAIL miss_req_drop: got %b want 0", mem_req); end
        checks++; if (ld_grant !== 1'b1)  begin errors++; $display("FAIL miss_regrant: got %b want 1", ld_grant); end
        checks++; if (stall !== 1'b0)     begin errors++; $display("FAIL miss_unstall: got %b want 0", stall); end
    endtask

    task automatic test_full_priority;
        @(negedge clk);
        drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h240, 32'h12345678, 1'b1);
        #1;
        checks++; if (dc_addr !== 32'h240)  begin errors++; $display("FAIL full_addr: got %h want 240", dc_addr); end
        checks++; if (ld_grant !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL full_arb: grant %b stall %b want 0 1", ld_grant, stall); end
        @(negedge clk);
        #1;
        checks++; if (sb_pop !== 1'b1 || dc_we !== 1'b1) begin errors++; $display("FAIL full_drain: pop %b we %b want 1 1", sb_pop, dc_we); end
        checks++; if (dc_wdata !== 32'h12345678) begin errors++; $display("FAIL full_wdata: got %h want 12345678", dc_wdata); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall2: got %b want 1", stall); end
        @(negedge clk);
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        #1;
        checks++; if (ld_grant !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL full_then_load: grant %b stall %b want 1 0", ld_grant, stall); end
    endtask

    task automatic test_starve;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h300, 32'hA5A50001, 1'b1);
            #1;
            checks++; if (ld_grant !== 1'b1 || sb_pop !== 1'b0) begin errors++; $display("FAIL starve_grant[%0d]: grant %b pop %b want 1 0", i, ld_grant, sb_pop); end
        end
        @(negedge clk);
        #1;
        checks++; if (ld_grant !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL starve_force: grant %b stall %b want 0 1", ld_grant, stall); end
        checks++; if (dc_addr !== 32'h300) begin errors++; $display("FAIL starve_addr: got %h want 300", dc_addr); end
        @(negedge clk);
        #1;
        checks++; if (sb_pop !== 1'b1 || dc_wdata !== 32'hA5A50001) begin errors++; $display("FAIL starve_pop: pop %b data %h want 1 a5a50001", sb_pop, dc_wdata); end
        @(negedge clk);
        #1;
        checks++; if (ld_grant !== 1'b1) begin errors++; $display("FAIL starve_cleared: got %b want 1", ld_grant); end
    endtask

    task automatic test_reset_in_fill;
        @(negedge clk);
        drive(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin errors++; $display("FAIL rf_pre: req %b addr %h want 1 400", mem_req, mem_addr); end
        reset = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rf_async: req %b stall %b want 0 0", mem_req, stall); end
        checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL rf_addr: got %h want 0", mem_addr); end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rf_idle: req %b stall %b want 0 0", mem_req, stall); end
        @(negedge clk);
        drive(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        #1;
        checks++; if (ld_grant !== 1'b1) begin errors++; $display("FAIL rf_grant: got %b want 1", ld_grant); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_hit();
        test_drain();
        test_miss();
        test_full_priority();
        test_starve();
        test_reset_in_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sb_drain_arb
`default_nettype wire

// File: doc/sb_drain_arb.md
SB_DRAIN_ARB -- requirements
Module: sb_drain_arb

Interface
REQ-001 SHALL have parameter MISS_LAT, default 4: cycles from mem_req to fill data valid.
REQ-002 SHALL have parameter STARVE_MAX, default 3: consecutive drain-denied cycles before a forced drain.
REQ-003 SHALL have port clk  input  1  single clock; all flops on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high.
REQ-005 SHALL have port ld_req  input  1  pipeline load wants the D-cache port this cycle.
REQ-006 SHALL have port ld_addr  input  32  load address.
REQ-007 SHALL have port sb_valid  input  1  store-buffer head entry valid.
REQ-008 SHALL have port sb_full  input  1  store buffer holds 4 valid entries.
REQ-009 SHALL have port sb_addr  input  32  head entry address.
REQ-010 SHALL have port sb_data  input  32  head entry data.
REQ-011 SHALL have port dhit  input  1  combinational D-cache hit for dc_addr.
REQ-012 SHALL have port dc_addr  output  32  address driven to the D-cache.
REQ-013 SHALL have port dc_we  output  1  D-cache write strobe.
REQ-014 SHALL have port dc_wdata  output  32  D-cache write data.
REQ-015 SHALL have port sb_pop  output  1  one-cycle pulse; head entry retired.
REQ-016 SHALL have port ld_grant  output  1  load served this cycle (hit).
REQ-017 SHALL have port mem_req  output  1  memory fill request, held until fill completes.
REQ-018 SHALL have port mem_addr  output  32  miss address, word-aligned.
REQ-019 SHALL have port stall  output  1  pipeline must hold.

Function
REQ-020 SHALL implement FSM states IDLE, DRAIN, MISS, FILL.
REQ-021 In IDLE, arbitration priority SHALL be: forced drain (sb_full or starve count = STARVE_MAX), then load, then opportunistic drain when sb_valid and no ld_req.
REQ-022 Load winner: dc_addr=ld_addr, dc_we=0; dhit=1 -> ld_grant=1, same cycle, stay IDLE; dhit=0 -> latch miss addr and requester=LOAD, go MISS, stall=1.
REQ-023 Drain winner: dc_addr=sb_addr; dhit=1 -> go DRAIN; dhit=0 -> latch addr and requester=STORE, go MISS.
REQ-024 DRAIN SHALL last exactly one cycle: dc_we=1, dc_wdata=sb_data, sb_pop=1, return to IDLE.
REQ-025 MISS SHALL assert mem_req and mem_addr (latched, bits [1:0]=0) and load a down-counter with MISS_LAT-1; move to FILL next cycle.
REQ-026 FILL SHALL hold mem_req and decrement; at count 0, return to IDLE, the requester re-arbitrating and hitting in the following cycle.
REQ-027 stall SHALL be 1 whenever ld_req=1 and ld_grant=0, and in MISS/FILL regardless of ld_req.
REQ-028 Starve counter (2 bits, saturating at STARVE_MAX) SHALL increment each IDLE cycle with sb_valid=1 and a load granted; it SHALL clear on sb_pop or sb_valid=0.
REQ-029 Simultaneous sb_full and ld_req SHALL serve the drain; the load stalls.
REQ-030 sb_pop SHALL never assert when sb_valid=0; dc_we SHALL never assert outside DRAIN.
REQ-031 Outputs not named active in a state SHALL be 0 (dc_addr/dc_wdata 0).

Reset
REQ-032 reset SHALL force IDLE, starve and latency counters 0, latched miss address 0, and every output 0, asynchronously.
REQ-033 Reset during MISS/FILL SHALL abandon the fill; mem_req SHALL drop with reset.

Structure
REQ-034 State encoding (2-bit), requester enum {LOAD, STORE}, and default MISS_LAT/STARVE_MAX SHALL live in shared package proc_pkg.
REQ-035 Single module; no sub-modules; latency counter width sized by $clog2(MISS_LAT).

Verification
REQ-036 ld_req=1, ld_addr=0x100, dhit=1, sb_valid=0 -> ld_grant=1 same cycle, stall=0, dc_we=0.
REQ-037 sb_valid=1, sb_addr=0x200, sb_data=0xDEADBEEF, no ld_req, dhit=1 -> next cycle dc_we=1, dc_wdata=0xDEADBEEF, sb_pop=1 for one cycle.
REQ-038 ld_req=1 at 0x304, dhit=0 -> mem_req high 4 cycles, mem_addr=0x304, stall high throughout, ld_grant on hit after return to IDLE.
REQ-039 sb_full=1 and ld_req=1 with dhit=1 -> drain served first, stall=1 for 2 cycles, then load granted.
REQ-040 ld_req held 1 with sb_valid=1, dhit=1 -> 3 load grants, then forced drain (sb_pop) on the 4th arbitration.
REQ-041 reset asserted in FILL count 2 -> mem_req, stall 0 immediately; IDLE after release.
